prio_encoder_pipe: RTL and testbench
====================================

// Module: prio_encoder_pipe
// PURPOSE
//  Parametrised N-to-log2(N) priority encoder with enable, registered output and valid/ready flow control.
//  - Generalises the fixed 8x3 enabled encoder to any input width.
//  - Adds a valid and multi-hit flag on every result.
//  - Adds an optional round-robin priority mode for request arbitration.
//  - Sits between request sources and a consumer that can stall.
// PARAMETERS
//  N   8            number of request inputs, N >= 2
//  W   $clog2(N)    localparam, output index width (3 for N=8)
// PORTS
//  clk        in   1  clock, rising edge
//  rst        in   1  reset, asynchronous, active-high
//  i          in   N  request vector
//  e          in   1  encoder enable, sampled with i
//  in_valid   in   1  i/e valid this cycle
//  in_ready   out  1  block can accept i/e this cycle
//  y          out  W  encoded index of the winning request
//  any        out  1  at least one request seen while enabled
//  multi      out  1  more than one request bit was set while enabled
//  out_valid  out  1  y/any/multi hold a result
//  out_ready  in   1  consumer takes the result this cycle
// BEHAVIOUR
//  - Reset (async, immediate, any time):
//    - Clears out_valid, y, any, multi and the rr pointer (ptr) to 0.
//    - An in-flight or stalled result is discarded.
//    - First acceptance is possible on the first clk edge after rst deasserts.
//  - in_ready = !out_valid || out_ready (combinational, single output register).
//  - Accept: in_valid && in_ready at a clk edge.
//    - Result registers load on that edge; out_valid = 1 after the edge.
//    - Latency is 1 cycle. Throughput is 1 result per cycle while out_ready = 1.
//  - Hold: out_valid && !out_ready keeps y/any/multi/out_valid stable; i/e are ignored.
//  - Drain: out_ready && out_valid && !in_valid clears out_valid on the next edge; y keeps its last value.
//  - Simultaneous drain and accept: the new result replaces the old one in the same edge, with no bubble.
//  - Encoding on accept:
//    - e = 0: y = 0, any = 0, multi = 0, regardless of i.
//    - e = 1, i = 0: y = 0, any = 0, multi = 0.
//    - e = 1, i != 0: any = 1; multi = 1 when popcount(i) > 1.
//    - e = 1, i != 0, fixed mode: y = index of highest set bit (i[N-1] has top priority).
//    - A one-hot input k always gives y = k.
//  - ptr (round-robin mode only):
//    - ptr is W bits and counts modulo N.
//    - ptr is updated only on an accept with e = 1 and any = 1: ptr <= (y + 1) mod N.
//    - Otherwise ptr is unchanged, including during hold.
//  - For N not a power of 2, y never exceeds N-1 and ptr wraps N-1 -> 0.
// CONFIGURATION
//  - PRIO_ENC_ROUND_ROBIN_EN undefined: fixed priority, highest index wins; no ptr register is built.
//  - PRIO_ENC_ROUND_ROBIN_EN defined: round-robin priority.
//    - Search order is ascending from ptr: ptr, ptr+1, ..., N-1, 0, ..., ptr-1; the first set bit wins.
//    - ptr updates as above.
//    - any, multi, enable and handshake behaviour are identical to fixed mode.
// TESTING
//  1. Fixed mode, out_ready = 1, e = 1, i = 1<<k for k = 0..7:
//     -> y = k, any = 1, multi = 0, out_valid = 1, one cycle after each accept.
//  2. e = 0, i = 8'h80 -> y = 0, any = 0, multi = 0, out_valid = 1.
//     Then e = 1, i = 8'h00 -> y = 0, any = 0.
//  3. e = 1, i = 8'b1010_0100 -> y = 7, multi = 1.
//     Then i = 8'b0000_0110 -> y = 2, multi = 1.
//  4. Backpressure: accept i = 8'h10, then hold out_ready = 0 for 3 cycles with in_valid = 1, i = 8'h01:
//     -> in_ready = 0 and y = 4 stable for all 3 cycles.
//     Raise out_ready -> next edge accepts, y = 0.
//  5. ROUND_ROBIN_EN, reset, e = 1, i = 8'hFF for 4 accepts -> y = 0, 1, 2, 3 (ptr = 4).
//     Then i = 8'b1000_0001 twice -> y = 7, then y = 0 (wrap).
//  6. Stall with out_valid = 1; pulse rst between clk edges:
//     -> out_valid, y, any, multi and ptr drop to 0 immediately, not at the next edge.
//     After release, i = 8'h08 -> y = 3.

Source files
------------

// File: rtl/prio_encoder_pipe.sv
// prio_encoder_pipe
//   Purpose : N-to-log2(N) priority encoder with enable, registered result
//             (index, any-hit, multi-hit) and valid/ready flow control.
//   Latency : 1 cycle from accept (in_valid && in_ready) to out_valid.
//   Backpressure: single output register; in_ready = !out_valid || out_ready,
//             so a stalled result blocks new input, and drain+accept in the
//             same cycle replaces the result with no bubble.
//
// Ports:
//   clk, rst             rising-edge clock, async active-high reset
//   i[N-1:0], e          request vector and enable, sampled on accept
//   in_valid / in_ready  input handshake
//   y[W-1:0]             winning request index
//   any                  at least one request while enabled
//   multi                more than one request while enabled
//   out_valid / out_ready output handshake
//
// Configuration:
//   PRIO_ENC_ROUND_ROBIN_EN undefined : fixed priority, i[N-1] wins.
//   PRIO_ENC_ROUND_ROBIN_EN defined   : round-robin; search ascends from a
//       pointer that moves to (winner + 1) mod N on every enabled hit.

module prio_encoder_pipe #(
    parameter int N = 8,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i,
    input  logic         e,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] y,
    output logic         any,
    output logic         multi,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] y_q, y_d;
    logic         any_q, any_d;
    logic         multi_q, multi_d;
    logic         out_valid_q, out_valid_d;

    logic         accept;
    logic         req_any;
    logic         req_multi;
    logic [W-1:0] hit_idx;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    assign req_any   = |i;
    assign req_multi = ($countones(i) > 1);

`ifdef PRIO_ENC_ROUND_ROBIN_EN
    logic [W-1:0] ptr_q, ptr_d;

    // Walk offsets from farthest to nearest so the last assignment is the
    // first set bit at or after ptr in circular ascending order.
    always_comb begin
        hit_idx = '0;
        for (int off = N - 1; off >= 0; off--) begin
            int unsigned idx;
            idx = (int'(ptr_q) + off) % N;
            if (i[idx]) begin
                hit_idx = W'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept && e && req_any) begin
            // Explicit wrap keeps ptr inside 0..N-1 when N is not a power of 2.
            ptr_d = (hit_idx == W'(N - 1)) ? '0 : hit_idx + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Ascending scan: the highest set bit is the last to assign.
    always_comb begin
        hit_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (i[k]) begin
                hit_idx = W'(k);
            end
        end
    end
`endif

    always_comb begin
        y_d         = y_q;
        any_d       = any_q;
        multi_d     = multi_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d = 1'b1;
            any_d       = e && req_any;
            multi_d     = e && req_multi;
            y_d         = (e && req_any) ? hit_idx : '0;
        end else if (out_ready) begin
            // Drain: index/flags keep their last value, only valid drops.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q         <= '0;
            any_q       <= 1'b0;
            multi_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            any_q       <= any_d;
            multi_q     <= multi_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign y         = y_q;
    assign any       = any_q;
    assign multi     = multi_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// tb_prio_encoder_pipe
//   Directed cases plus a random phase; expected results are queued on each
//   accepted input and compared when the output handshake completes.

module tb_prio_encoder_pipe;

    localparam int N = 8;
    localparam int W = 3;
`ifdef PRIO_ENC_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] y;
        logic         any;
        logic         multi;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] i;
    logic         e;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] y;
    logic         any;
    logic         multi;
    logic         out_valid;
    logic         out_ready;

    int err_cnt = 0;
    int chk_cnt = 0;

    exp_t         sb[$];
    logic [W-1:0] ptr_m;

    prio_encoder_pipe #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .i         (i),
        .e         (e),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .any       (any),
        .multi     (multi),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference encoder: fixed scans down from the top bit, round-robin scans
    // up from the model pointer.
    function automatic exp_t model(input logic [N-1:0] iv, input logic ev, input logic [W-1:0] p);
        exp_t r;
        int   cnt;
        r.y = '0; r.any = 1'b0; r.multi = 1'b0;
        cnt = 0;
        for (int k = 0; k < N; k++) if (iv[k]) cnt++;
        if (ev && cnt > 0) begin
            r.any   = 1'b1;
            r.multi = (cnt > 1);
            if (RR) begin
                for (int off = N - 1; off >= 0; off--)
                    if (iv[(int'(p) + off) % N]) r.y = W'((int'(p) + off) % N);
            end else begin
                for (int k = 0; k < N; k++)
                    if (iv[N - 1 - k] && !r.any) r.y = W'(N - 1 - k);
                for (int k = N - 1; k >= 0; k--)
                    if (iv[k]) begin r.y = W'(k); break; end
            end
        end
        return r;
    endfunction

    // Scoreboard: sampled at the negedge, inputs only change at posedge+1.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    chk("sb_y", 32'(y), 32'(x.y));
                    chk("sb_any", 32'(any), 32'(x.any));
                    chk("sb_multi", 32'(multi), 32'(x.multi));
                end
            end
            if (in_valid && in_ready) begin
                exp_t x;
                x = model(i, e, ptr_m);
                sb.push_back(x);
                if (RR && e && x.any) ptr_m = (x.y == W'(N - 1)) ? '0 : x.y + W'(1);
            end
        end
    end

    task automatic drive(input logic [N-1:0] iv, input logic ev);
        in_valid = 1'b1;
        i        = iv;
        e        = ev;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; i = '0; e = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ptr_m = '0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_any", 32'(any), 32'd0);
        chk("rst_multi", 32'(multi), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // One-hot inputs, full throughput.
        for (int k = 0; k < N; k++) begin
            drive(8'(1 << k), 1'b1);
            chk("onehot_valid", 32'(out_valid), 32'd1);
            chk("onehot_y", 32'(y), 32'(k));
        end
        idle();
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_y_kept", 32'(y), 32'd7);

        // Enable low and empty request.
        drive(8'h80, 1'b0);
        chk("en0_valid", 32'(out_valid), 32'd1);
        chk("en0_any", 32'(any), 32'd0);
        chk("en0_y", 32'(y), 32'd0);
        drive(8'h00, 1'b1);
        chk("empty_any", 32'(any), 32'd0);

        // Multi-hit.
        drive(8'b1010_0100, 1'b1);
        chk("multi_a", 32'(multi), 32'd1);
        if (!RR) chk("multi_a_y", 32'(y), 32'd7);
        drive(8'b0000_0110, 1'b1);
        chk("multi_b", 32'(multi), 32'd1);
        if (!RR) chk("multi_b_y", 32'(y), 32'd2);
        idle();

        // Backpressure hold.
        drive(8'h10, 1'b1);
        out_ready = 1'b0;
        in_valid  = 1'b1; i = 8'h01; e = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_y", 32'(y), 32'd4);
            chk("hold_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("release_y", 32'(y), 32'd0);
        idle();

`ifdef PRIO_ENC_ROUND_ROBIN_EN
        // Round-robin from a freshly reset pointer.
        rst = 1'b1; sb.delete(); ptr_m = '0;
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(8'hFF, 1'b1);
            chk("rr_ff_y", 32'(y), 32'(k));
        end
        drive(8'b1000_0001, 1'b1);
        chk("rr_wrap_a", 32'(y), 32'd7);
        drive(8'b1000_0001, 1'b1);
        chk("rr_wrap_b", 32'(y), 32'd0);
        idle();
`endif

        // Asynchronous reset while stalled.
        out_ready = 1'b0;
        drive(8'h06, 1'b1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; sb.delete(); ptr_m = '0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_y", 32'(y), 32'd0);
        chk("arst_any", 32'(any), 32'd0);
        chk("arst_multi", 32'(multi), 32'd0);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        drive(8'b1000_0001, 1'b1);
        chk("post_rst_ptr", 32'(y), RR ? 32'd0 : 32'd7);
        drive(8'h08, 1'b1);
        chk("post_rst_y", 32'(y), 32'd3);
        idle();

        // Random traffic with random stalls.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            i         = ($urandom_range(0, 4) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
            e         = ($urandom_range(0, 7) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
